// File: rtl/traffic_light_pkg.sv
// ---------------------------------------------------------------------------
// traffic_light_pkg
// Shared definitions for the N-approach traffic light controller:
//   - FSM state codes (kept as plain 3-bit constants so the encoding is
//     visible on the present_state / next_state ports)
//   - colour bit offsets inside each approach's 3-bit lights field
//   - default durations and sizes used as parameter defaults
//   - colour_bits(): one-hot 3-bit field for a given colour offset
// ---------------------------------------------------------------------------
package traffic_light_pkg;

   localparam logic [2:0] ST_ALLRED  = 3'd0;
   localparam logic [2:0] ST_GREEN   = 3'd1;
   localparam logic [2:0] ST_YELLOW  = 3'd2;
   localparam logic [2:0] ST_PREEMPT = 3'd3;

   localparam int RED = 0;
   localparam int YEL = 1;
   localparam int GRN = 2;

   localparam int DEF_NUM_DIR    = 4;
   localparam int DEF_GREEN_CYC  = 8;
   localparam int DEF_YELLOW_CYC = 2;
   localparam int DEF_ALLRED_CYC = 1;
   localparam int DEF_TW         = 8;

   // Builds the 3-bit lights field of one approach with only the requested
   // colour lit, so every approach always shows exactly one colour.
   function automatic logic [2:0] colour_bits(input int colour);
      logic [2:0] f;
      f = 3'b000;
      f[colour] = 1'b1;
      return f;
   endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// ---------------------------------------------------------------------------
// tl_rr_pick
// Combinational round-robin search. Starting just after the current index
// and wrapping around (the current index itself is checked last), returns
// the first requesting position.
// Ports:
//   req   in  N   request vector
//   cur   in  AW  index served last
//   found out 1   at least one request is set
//   idx   out AW  first requester after cur (cur when nothing is found)
// ---------------------------------------------------------------------------
module tl_rr_pick #(
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [AW-1:0] cur,
   output logic          found,
   output logic [AW-1:0] idx
);

   // Walk the offsets from farthest to nearest so the nearest requester
   // (smallest offset after cur) is the last one written and wins.
   always_comb begin
      int p;
      found = 1'b0;
      idx   = cur;
      p     = 0;
      for (int k = N; k >= 1; k--) begin
         p = (int'(cur) + k) % N;
         if (req[p]) begin
            found = 1'b1;
            idx   = AW'(p);
         end
      end
   end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_n
// Round-robin traffic light controller for NUM_DIR approaches with green
// extension and emergency preemption.
// Optional feature macro: TRAFFIC_PED_WALK_EN (pedestrian request latches
// and walk outputs).
// Ports:
//   clk           in  1          single clock, rising edge
//   rst           in  1          synchronous active-high reset
//   V             in  NUM_DIR    per-approach vehicle demand (level)
//   Z             in  1          emergency preempt (level)
//   ped_req       in  NUM_DIR    pedestrian request pulses (macro only)
//   walk          out NUM_DIR    walk indication (macro only)
//   lights        out 3*NUM_DIR  approach i: bit 3i red, 3i+1 yellow, 3i+2 green
//   present_state out 3          registered FSM state
//   next_state    out 3          combinational next state
//   active_dir    out AW         registered index of the approach served
// ---------------------------------------------------------------------------
module traffic_light_ctrl_n
   import traffic_light_pkg::*;
#(
   parameter int NUM_DIR    = DEF_NUM_DIR,
   parameter int GREEN_CYC  = DEF_GREEN_CYC,
   parameter int YELLOW_CYC = DEF_YELLOW_CYC,
   parameter int ALLRED_CYC = DEF_ALLRED_CYC,
   parameter int TW         = DEF_TW,
   localparam int AW        = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_DIR-1:0]   V,
   input  logic                 Z,
`ifdef TRAFFIC_PED_WALK_EN
   input  logic [NUM_DIR-1:0]   ped_req,
   output logic [NUM_DIR-1:0]   walk,
`endif
   output logic [3*NUM_DIR-1:0] lights,
   output logic [2:0]           present_state,
   output logic [2:0]           next_state,
   output logic [AW-1:0]        active_dir
);

   localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_CYC - 1);
   localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_CYC - 1);
   localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_CYC - 1);
   localparam logic [TW-1:0] ONE       = TW'(1);

   logic [TW-1:0]      timer;
   logic [TW-1:0]      timer_nxt;
   logic [AW-1:0]      dir_nxt;
   logic [NUM_DIR-1:0] demand;
   logic [NUM_DIR-1:0] other_demand;
   logic               expired;
   logic               pick_found;
   logic [AW-1:0]      pick_idx;
   logic               green_entry;

`ifdef TRAFFIC_PED_WALK_EN
   logic [NUM_DIR-1:0] ped_latch;
   logic               walk_flag;

   assign demand = V | ped_latch;
`else
   assign demand = V;
`endif

   assign expired     = (timer == '0);
   assign green_entry = (present_state == ST_ALLRED) && (next_state == ST_GREEN);

   // Demand from every approach except the one currently being served;
   // decides whether an expiring green may simply be extended.
   always_comb begin
      other_demand = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         other_demand[i] = demand[i] && (i != int'(active_dir));
      end
   end

   tl_rr_pick #(
      .N  (NUM_DIR),
      .AW (AW)
   ) u_pick (
      .req   (demand),
      .cur   (active_dir),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next-state, timer reload and direction selection. The default branch
   // sends the unused codes 4..7 back to ALLRED with a fresh clearance time.
   // PREEMPT has no duration of its own, so it keeps the ALLRED reload value
   // ready for the moment Z drops.
   always_comb begin
      next_state = ST_ALLRED;
      timer_nxt  = ALLRED_LD;
      dir_nxt    = active_dir;
      case (present_state)
         ST_ALLRED: begin
            if (Z) begin
               next_state = ST_PREEMPT;
            end else if (expired) begin
               if (pick_found) begin
                  next_state = ST_GREEN;
                  timer_nxt  = GREEN_LD;
                  dir_nxt    = pick_idx;
               end
            end else begin
               timer_nxt = timer - ONE;
            end
         end
         ST_GREEN: begin
            if (Z) begin
               next_state = ST_YELLOW;
               timer_nxt  = YELLOW_LD;
            end else if (expired) begin
               if (demand[active_dir] && (other_demand == '0)) begin
                  next_state = ST_GREEN;
                  timer_nxt  = GREEN_LD;
               end else begin
                  next_state = ST_YELLOW;
                  timer_nxt  = YELLOW_LD;
               end
            end else begin
               next_state = ST_GREEN;
               timer_nxt  = timer - ONE;
            end
         end
         ST_YELLOW: begin
            if (!expired) begin
               next_state = ST_YELLOW;
               timer_nxt  = timer - ONE;
            end
         end
         ST_PREEMPT: begin
            if (Z) begin
               next_state = ST_PREEMPT;
            end
         end
         default: begin
            next_state = ST_ALLRED;
         end
      endcase
   end

   // State, timer and served direction registers. Reset parks the controller
   // in ALLRED pointing at the last approach so the first scan starts at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         present_state <= ST_ALLRED;
         timer         <= ALLRED_LD;
         active_dir    <= AW'(NUM_DIR - 1);
      end else begin
         present_state <= next_state;
         timer         <= timer_nxt;
         active_dir    <= dir_nxt;
      end
   end

   // Moore light decode: only the served approach may leave red, and only
   // while in GREEN or YELLOW.
   always_comb begin
      lights = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         if ((i == int'(active_dir)) && (present_state == ST_GREEN)) begin
            lights[3*i +: 3] = colour_bits(GRN);
         end else if ((i == int'(active_dir)) && (present_state == ST_YELLOW)) begin
            lights[3*i +: 3] = colour_bits(YEL);
         end else begin
            lights[3*i +: 3] = colour_bits(RED);
         end
      end
   end

`ifdef TRAFFIC_PED_WALK_EN
   // Pedestrian latches collect request pulses and act as demand. The latch
   // of the approach entering GREEN is consumed on that edge, and its value
   // decides whether walk is shown for the whole green phase (extensions
   // included). A pulse arriving on the entry edge itself is consumed too.
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_latch <= '0;
         walk_flag <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_DIR; i++) begin
            if (green_entry && (i == int'(dir_nxt))) begin
               ped_latch[i] <= 1'b0;
            end else begin
               ped_latch[i] <= ped_latch[i] | ped_req[i];
            end
         end
         if (green_entry) begin
            walk_flag <= ped_latch[pick_idx];
         end else if (next_state != ST_GREEN) begin
            walk_flag <= 1'b0;
         end
      end
   end

   // Walk is shown only on the served approach and only during GREEN.
   always_comb begin
      walk = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         walk[i] = walk_flag && (present_state == ST_GREEN) && (i == int'(active_dir));
      end
   end
`endif

endmodule
